fft_frame_feeder: RTL
=====================

Name: fft_frame_feeder

Overview:
- Fetches one FFT frame of complex samples from a synchronous-read sample RAM and drives it, framed and backpressure-aware, into the sink side of the variable-size streaming FFT core (valid/ready, sop/eop, real/imag, fftpts).
- Sits between the charge-grid memory and the FFT core on the forward-transform path; one command produces one frame.

Parameters:
- DATA_W, 32, width of each of real and imag.
- ADDR_W, 10, sample RAM address width.
- NPTS_W, 6, width of point-count field (max 32 points).
- FIFO_DEPTH, 4, output buffer entries (power of 2, >=3).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  frame request.
- cmd_ready  out  1  feeder idle, can accept a command.
- cmd_base  in  ADDR_W  first sample address.
- cmd_npts  in  NPTS_W  frame length; legal values 4, 8, 16, 32.
- cmd_err  out  1  one-cycle pulse: command rejected (illegal npts).
- done  out  1  one-cycle pulse: eop beat accepted downstream.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  2*DATA_W  {imag, real}, valid exactly 1 cycle after rd_en.
- st_valid  out  1  to FFT sink_valid.
- st_ready  in  1  from FFT sink_ready.
- st_sop  out  1  first beat of frame.
- st_eop  out  1  last beat of frame.
- st_real  out  DATA_W  sample real.
- st_imag  out  DATA_W  sample imag.
- st_fftpts  out  NPTS_W  frame length, constant for the whole frame.
- st_error  out  2  tied 2'b00.

Behaviour:
- Reset (async, reset_n low): all outputs 0 except cmd_ready=1. FIFO emptied, counters cleared, FSM to IDLE. Reset mid-frame abandons the frame; no eop or done is emitted for it.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid with legal npts, latch base/npts and go to FETCH. Illegal npts: pulse cmd_err the next cycle and stay in IDLE; no reads, no beats.
  - FETCH: issue reads until npts reads are issued, then go to DRAIN.
  - DRAIN: wait for the eop beat handshake, pulse done, return to IDLE.
  - cmd_ready=0 in FETCH and DRAIN.
- Read issue rule: rd_en=1 in a cycle iff state is FETCH, reads remaining >0, and fifo_count + in_flight < FIFO_DEPTH, where in_flight is 0 or 1 (read issued in the previous cycle). This guarantees the FIFO never overflows.
- Address: rd_addr = (base + index) mod 2^ADDR_W; wrap-around is legal.
- rd_data is written into the FIFO in the cycle after rd_en, tagged with sop (index 0) and eop (index npts-1).
- Stream outputs come from the FIFO head; st_valid = FIFO not empty. A beat transfers on st_valid && st_ready.
- While st_valid=1 and st_ready=0, all st_* outputs are held stable.
- st_fftpts is driven from the latched npts whenever st_valid=1.
- Latency: command accepted at edge 0 -> rd_en in cycle 1 -> st_valid with sop in cycle 3.
- Throughput: with st_ready held high, one beat per cycle with no bubbles; a 32-point frame occupies cycles 3..34.
- A simultaneous FIFO push and pop in the same cycle leaves the count unchanged.
- done pulses in the cycle after the eop handshake; cmd_ready returns to 1 in that same cycle. The next command can be accepted then, giving a 3-cycle inter-frame gap.

Decomposition:
- Package fft_feed_pkg holds DATA_W, NPTS_W, the legal-npts check function, the {eop, sop, imag, real} FIFO entry struct, and the FSM state enum.
- One sub-module, fft_feed_fifo: a synchronous FIFO with count output, FIFO_DEPTH entries, async active-low reset. The top level holds the FSM, address/index counters, and the credit logic.

Test Plan:
- RAM[i] = {i+0x100, i}, cmd base=0 npts=32, st_ready=1 -> 32 consecutive beats in cycles 3..34, real=0..31, sop on beat 0 only, eop on beat 31 only, fftpts=32, done once.
- Same frame with st_ready toggled pseudo-randomly (about 50%) -> identical beat sequence, outputs stable during stalls, no more than FIFO_DEPTH reads outstanding beyond accepted beats.
- cmd npts=12 -> cmd_err single pulse, zero rd_en, zero st_valid, cmd_ready stays 1; a following npts=8 command completes normally.
- base=2^ADDR_W-2, npts=4 -> rd_addr sequence 1022, 1023, 0, 1; beats match those RAM words.
- Back-to-back cmd_valid held high with npts=16 then 4 -> second command accepted only in the cycle done pulses; fftpts switches 16 -> 4 exactly at the second frame's sop.
- reset_n asserted at beat 10 of a 32-point frame -> all outputs 0 and cmd_ready=1 immediately; after release, a new npts=4 frame delivers 4 beats with correct sop/eop.

Source files
------------

// File: rtl/fft_feed_pkg.sv
// fft_feed_pkg: shared widths, FIFO entry layout and FSM states for the FFT frame feeder
package fft_feed_pkg;
  localparam int DATA_W = 32;
  localparam int NPTS_W = 6;
  typedef struct packed {
    logic              eop;
    logic              sop;
    logic [DATA_W-1:0] im;
    logic [DATA_W-1:0] re;
  } entry_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  function automatic logic npts_legal(input logic [NPTS_W-1:0] n);
    return n == NPTS_W'(4) || n == NPTS_W'(8) || n == NPTS_W'(16) || n == NPTS_W'(32);
  endfunction
endpackage

// File: rtl/fft_feed_fifo.sv
// fft_feed_fifo: synchronous FIFO of tagged samples with occupancy count
module fft_feed_fifo
  import fft_feed_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign dout = mem[rp];
endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: reads one frame of complex samples from RAM and streams it
// into the FFT sink with sop/eop framing, credit-limited so the FIFO never overflows.
module fft_frame_feeder
  import fft_feed_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [NPTS_W-1:0]   cmd_npts,
  output logic                cmd_err,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [2*DATA_W-1:0] rd_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop,
  output logic [DATA_W-1:0]   st_real,
  output logic [DATA_W-1:0]   st_imag,
  output logic [NPTS_W-1:0]   st_fftpts,
  output logic [1:0]          st_error
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t            state, state_n;
  logic [ADDR_W-1:0] base;
  logic [NPTS_W-1:0] npts, idx;
  logic              in_flight, fl_sop, fl_eop, pop, accept;
  logic [CW-1:0]     count;
  entry_t            din, head;
  assign accept = cmd_ready && cmd_valid && npts_legal(cmd_npts);
  assign pop = st_valid && st_ready;
  assign din = '{eop: fl_eop, sop: fl_sop, im: rd_data[2*DATA_W-1:DATA_W], re: rd_data[DATA_W-1:0]};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // a read is only issued when a FIFO slot is guaranteed for its data, counting the one in flight
  always_comb begin
    cmd_ready = state == IDLE;
    rd_en = state == FETCH && idx < npts && 32'(count) + 32'(in_flight) < FIFO_DEPTH;
    state_n = state;
    if (accept) state_n = FETCH;
    if (state == FETCH && rd_en && idx == npts - NPTS_W'(1)) state_n = DRAIN;
    if (state == DRAIN && pop && head.eop) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      base <= '0;
      npts <= '0;
      idx <= '0;
      in_flight <= 1'b0;
      fl_sop <= 1'b0;
      fl_eop <= 1'b0;
      cmd_err <= 1'b0;
      done <= 1'b0;
    end else begin
      in_flight <= rd_en;
      fl_sop <= idx == '0;
      fl_eop <= idx == npts - NPTS_W'(1);
      cmd_err <= cmd_ready && cmd_valid && !npts_legal(cmd_npts);
      done <= pop && head.eop;
      if (accept) begin
        base <= cmd_base;
        npts <= cmd_npts;
        idx <= '0;
      end else if (rd_en) idx <= idx + NPTS_W'(1);
    end
  fft_feed_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(in_flight), .din(din),
    .pop(pop), .dout(head), .count(count)
  );
  assign rd_addr = rd_en ? base + ADDR_W'(idx) : '0;
  assign st_valid = count != '0;
  assign st_sop = st_valid && head.sop;
  assign st_eop = st_valid && head.eop;
  assign st_real = st_valid ? head.re : '0;
  assign st_imag = st_valid ? head.im : '0;
  assign st_fftpts = st_valid ? npts : '0;
  assign st_error = 2'b00;
endmodule
